// File: rtl/led_pwm_ctrl.sv
// PWM dimming and overcurrent protection controller for the analog LED current regulator.
// Soft-ramps the applied duty toward a programmed target and retries or locks out on overcurrent.
//
// state | meaning
// IDLE  | disabled, all counters cleared, waiting for en
// RAMP  | PWM active, duty_cur steps one LSB per period toward target
// RUN   | PWM active at target duty, fault count cleared on entry
// FAULT | PWM off, ovc ignored, retry timer running
// LOCK  | PWM off after too many faults, only en=0 leaves
module led_pwm_ctrl #(
    parameter int CNT_W        = 8,
    parameter int DEB          = 4,
    parameter int RETRY_CYCLES = 1024,
    parameter int MAX_RETRY    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] duty_i,
    input  logic             duty_load,
    input  logic             ovc_i,
    output logic             pwm_o,
    output logic [1:0]       mux_sel_o,
    output logic             fault_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] duty_cur_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_RUN   = 3'd2,
        S_FAULT = 3'd3,
        S_LOCK  = 3'd4
    } state_t;

    localparam int DEB_W = $clog2(DEB + 1);
    localparam int RT_W  = $clog2(RETRY_CYCLES + 1);
    localparam int FC_W  = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB);
    localparam logic [RT_W-1:0]  RT_LOAD  = RT_W'(RETRY_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_RETRY);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_duty_cur, w_duty_nxt;
    logic [CNT_W-1:0] r_target, w_target_nxt;
    logic [FC_W-1:0]  r_fault_cnt, w_fc_nxt;
    logic [DEB_W-1:0] r_deb_cnt, w_deb_nxt, w_deb_inc;
    logic [RT_W-1:0]  r_retry, w_retry_nxt;
    logic [1:0]       r_mux, w_mux_nxt;
    logic             r_ovc_meta, r_ovc_s;
    logic             r_pwm, w_pwm_nxt;
    logic             w_active, w_wrap, w_fault_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_duty_cur  <= '0;
            r_target    <= '0;
            r_fault_cnt <= '0;
            r_deb_cnt   <= '0;
            r_retry     <= '0;
            r_mux       <= '0;
            r_ovc_meta  <= 1'b0;
            r_ovc_s     <= 1'b0;
            r_pwm       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_duty_cur  <= w_duty_nxt;
            r_target    <= w_target_nxt;
            r_fault_cnt <= w_fc_nxt;
            r_deb_cnt   <= w_deb_nxt;
            r_retry     <= w_retry_nxt;
            r_mux       <= w_mux_nxt;
            r_ovc_meta  <= ovc_i;
            r_ovc_s     <= r_ovc_meta;
            r_pwm       <= w_pwm_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_duty_nxt   = r_duty_cur;
        w_target_nxt = duty_load ? duty_i : r_target;
        w_fc_nxt     = r_fault_cnt;
        w_retry_nxt  = r_retry;
        w_mux_nxt    = r_mux;

        w_active  = (r_state == S_RAMP) || (r_state == S_RUN);
        w_wrap    = (r_cnt == CNT_LAST);
        w_pwm_nxt = w_active && (r_cnt < r_duty_cur);

        // Debounce is frozen at zero while faulted so a retry needs a fresh DEB-long assertion.
        w_deb_inc = (r_deb_cnt == DEB_MAX) ? r_deb_cnt : r_deb_cnt + 1'b1;
        if (!r_ovc_s || (r_state == S_FAULT) || (r_state == S_LOCK))
            w_deb_nxt = '0;
        else
            w_deb_nxt = w_deb_inc;
        w_fault_det = w_active && r_ovc_s && (w_deb_inc == DEB_MAX);

        if (!w_active)
            w_mux_nxt = 2'b00;
        else if (r_cnt == '0)
            w_mux_nxt = r_duty_cur[CNT_W-1 -: 2];

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (en)
                    w_state_nxt = S_RAMP;
            end
            S_RAMP: begin
                w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
                if (w_wrap) begin
                    if (r_duty_cur == r_target) begin
                        w_state_nxt = S_RUN;
                        w_fc_nxt    = '0;
                    end else if (r_target > r_duty_cur) begin
                        w_duty_nxt = r_duty_cur + 1'b1;
                    end else begin
                        w_duty_nxt = r_duty_cur - 1'b1;
                    end
                end
            end
            S_RUN: begin
                w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
                if (w_wrap && (r_target != r_duty_cur))
                    w_state_nxt = S_RAMP;
            end
            S_FAULT: begin
                w_cnt_nxt = '0;
                if (r_retry == '0) begin
                    if (r_fault_cnt < FC_MAX) begin
                        w_state_nxt = S_RAMP;
                        w_duty_nxt  = '0;
                    end else begin
                        w_state_nxt = S_LOCK;
                    end
                end else begin
                    w_retry_nxt = r_retry - 1'b1;
                end
            end
            S_LOCK: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Fault entry overrides any ramp step or RAMP->RUN move on the same edge.
        if (w_fault_det) begin
            w_state_nxt = S_FAULT;
            w_cnt_nxt   = '0;
            w_duty_nxt  = r_duty_cur;
            w_retry_nxt = RT_LOAD;
            w_pwm_nxt   = 1'b0;
            w_fc_nxt    = (r_fault_cnt == {FC_W{1'b1}}) ? r_fault_cnt : r_fault_cnt + 1'b1;
        end

        if (!en) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_duty_nxt  = '0;
            w_fc_nxt    = '0;
            w_deb_nxt   = '0;
            w_retry_nxt = '0;
            w_pwm_nxt   = 1'b0;
            w_mux_nxt   = 2'b00;
        end
    end

    assign pwm_o      = r_pwm;
    assign mux_sel_o  = r_mux;
    assign fault_o    = (r_state == S_FAULT) || (r_state == S_LOCK);
    assign state_o    = r_state;
    assign duty_cur_o = r_duty_cur;

endmodule

// File: doc/led_pwm_ctrl.md
# led_pwm_ctrl

Digital dimming and protection controller that sits directly upstream of the analog LED current regulator. It generates the PWM enable that gates the regulator. It soft-ramps the duty cycle toward a programmed target. It drives the sense-range mux selects and consumes the overcurrent comparator output, with debounce, timed retry and lockout.

## Interface
- `CNT_W`, 8: PWM/duty resolution in bits; period = 2^CNT_W − 1 cycles (255).
- `DEB`, 4: consecutive synchronized `ovc_i` high cycles needed to declare a fault.
- `RETRY_CYCLES`, 1024: cycles spent in FAULT before retry.
- `MAX_RETRY`, 3: fault entries tolerated before LOCK.

- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: controller enable; low forces IDLE.
- `duty_i` in CNT_W: target duty.
- `duty_load` in 1: one-cycle strobe; latches `duty_i` into target.
- `ovc_i` in 1: overcurrent comparator output, asynchronous to `clk`.
- `pwm_o` out 1: regulator enable, registered.
- `mux_sel_o` out 2: sense-range select {S1,S0}, registered.
- `fault_o` out 1: high in FAULT or LOCK.
- `state_o` out 3: IDLE=0, RAMP=1, RUN=2, FAULT=3, LOCK=4.
- `duty_cur_o` out CNT_W: current applied duty.

## Operation
- Reset: all outputs 0, and target, `cnt`, fault count and debounce count all 0. State IDLE.
- `cnt` runs 0..254 and wraps to 0 in RAMP and RUN. It is held at 0 in the other states.
- Each edge, `pwm_o` ← (state ∈ {RAMP, RUN}) && (`cnt` < `duty_cur`).
  - Duty D gives exactly D high cycles per 255.
  - D = 255 gives continuous high. D = 0 gives never high.
- `duty_load` latches the target in every state, including FAULT and LOCK.
- IDLE → RAMP when `en` = 1.
- RAMP: at `cnt` = 254, `duty_cur` moves one step toward the target, up or down by 1.
  - At `cnt` = 254, if `duty_cur` already equals the target, the state goes to RUN instead.
- RUN: fault count is cleared on entry.
  - At `cnt` = 254, if the target differs from `duty_cur`, the state returns to RAMP.
- `ovc_i` passes through a 2-flop synchronizer to give `ovc_s`.
  - The debounce counter increments on each edge where `ovc_s` = 1 and clears when `ovc_s` = 0.
  - On the edge the counter reaches DEB while in RAMP or RUN, the state goes to FAULT, fault count +1 (saturating), and `pwm_o` = 0 on that same edge.
- FAULT: `ovc_s` is ignored and the retry timer counts RETRY_CYCLES. On expiry:
  - If fault count < MAX_RETRY: go to RAMP with `duty_cur` = 0 and `cnt` = 0.
  - Otherwise: go to LOCK.
- LOCK: `pwm_o` = 0. Exit only via `en` = 0.
- `en` = 0 in any state: next edge gives IDLE, and clears `duty_cur`, `cnt`, fault count, debounce count, retry timer and `pwm_o`. The target is kept.
- `mux_sel_o` is updated only on edges where `cnt` = 0, from `duty_cur`:
  - <64 → 00, <128 → 01, <192 → 10, else 11.
  - In IDLE, FAULT and LOCK it is held at 00.

## Timing
- `pwm_o` lags `cnt` by one cycle. No combinational input-to-output paths.
- Fault latency with `ovc_i` held high from first sampling edge E: FAULT and `pwm_o` = 0 at edge E+1+DEB (E+5 by default).
- An `ovc_i` pulse shorter than DEB synchronized cycles never faults.
- Ramp time from 0 to target T is T+1 periods, then RUN.
- Simultaneous events:
  - `en` = 0 beats fault detection and ramp steps.
  - `duty_load` together with fault entry: target updates and state is FAULT.
  - Fault detection beats a RAMP→RUN transition on the same edge.
- Assertion of `rst_n` mid-operation asynchronously forces all reset values. Release is sampled on the next `clk` edge.

## Test plan
- Reset, `en` = 1, load 4: `duty_cur_o` steps 0→4 at `cnt` = 254 boundaries; `state_o` = 2 after 5 periods; `pwm_o` high exactly 4 of every 255 cycles.
- Load 255, then 0 while in RUN: `pwm_o` continuously high, then ramps down and reaches RUN with `pwm_o` never high.
- `ovc_i` high 3 cycles: no fault. High ≥4 cycles in RUN: FAULT with `pwm_o` = 0 at E+5, `fault_o` = 1. After 1024 cycles: RAMP from `duty_cur` = 0.
- Three consecutive faults without reaching RUN: `state_o` = 4 (LOCK), `fault_o` = 1. Then `en` = 0: IDLE, `fault_o` = 0. Re-enable: ramps to the retained target.
- Target 200: `mux_sel_o` goes 00→01→10→11 at the first `cnt` = 0 after `duty_cur` reaches 64, 128 and 192.
- `rst_n` low mid-RUN with `pwm_o` high: all outputs 0 immediately, without waiting for a `clk` edge.
